axi4_lite_arbiter_2to1: RTL and testbench

- Shares one AXI4-Lite slave (the 32-word register-file slave) between two AXI4-Lite masters.
- One transaction is in flight at a time; masters are selected round-robin.
- Upstream ports S0_*/S1_* face the masters; downstream port M_* faces the slave.
- Sequences the slave's write-address/data, write-response, read-address and read-data phases on behalf of the granted master.

---
 rtl/axi4_lite_pkg.sv | 15 +
 rtl/rr_arbiter_2.sv | 14 +
 rtl/axi4_lite_arbiter_2to1.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi4_lite_arbiter_2to1.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and response codes for the two-master AXI4-Lite arbiter.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not served last.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any_req,
  output logic       gnt_idx
);

  always_comb begin
    any_req = |req;
    gnt_idx = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Shares one AXI4-Lite slave between two masters, one transaction at a time.
// state   | meaning
// IDLE    | no transaction; arbitrate between pending requests
// WR_ADDR | forward AW and W of the granted master until both handshake
// WR_RESP | forward B back to the granted master
// RD_ADDR | forward AR of the granted master
// RD_DATA | forward R back to the granted master
module axi4_lite_arbiter_2to1
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDRESS-1:0]      S0_AWADDR,
  input  logic                    S0_AWVALID,
  output logic                    S0_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
  input  logic                    S0_WVALID,
  output logic                    S0_WREADY,
  output logic [1:0]              S0_BRESP,
  output logic                    S0_BVALID,
  input  logic                    S0_BREADY,
  input  logic [ADDRESS-1:0]      S0_ARADDR,
  input  logic                    S0_ARVALID,
  output logic                    S0_ARREADY,
  output logic [DATA_WIDTH-1:0]   S0_RDATA,
  output logic [1:0]              S0_RRESP,
  output logic                    S0_RVALID,
  input  logic                    S0_RREADY,
  input  logic [ADDRESS-1:0]      S1_AWADDR,
  input  logic                    S1_AWVALID,
  output logic                    S1_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
  input  logic                    S1_WVALID,
  output logic                    S1_WREADY,
  output logic [1:0]              S1_BRESP,
  output logic                    S1_BVALID,
  input  logic                    S1_BREADY,
  input  logic [ADDRESS-1:0]      S1_ARADDR,
  input  logic                    S1_ARVALID,
  output logic                    S1_ARREADY,
  output logic [DATA_WIDTH-1:0]   S1_RDATA,
  output logic [1:0]              S1_RRESP,
  output logic                    S1_RVALID,
  input  logic                    S1_RREADY,
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  output logic                    GNT,
  output logic                    BUSY
);

  arb_state_t state, state_n;
  logic gnt, gnt_n, last, last_n;
  logic aw_done, aw_done_n, w_done, w_done_n;
  logic any_req, arb_gnt, win_awvalid;
  logic aw_hs, w_hs;

  logic [ADDRESS-1:0]      sg_awaddr, sg_araddr;
  logic [DATA_WIDTH-1:0]   sg_wdata;
  logic [DATA_WIDTH/8-1:0] sg_wstrb;
  logic sg_awvalid, sg_wvalid, sg_arvalid, sg_bready, sg_rready;

  logic                  up_awready, up_wready, up_arready, up_bvalid, up_rvalid;
  logic [1:0]            up_bresp, up_rresp;
  logic [DATA_WIDTH-1:0] up_rdata;

  rr_arbiter_2 u_rr (
    .req     ({S1_AWVALID | S1_ARVALID, S0_AWVALID | S0_ARVALID}),
    .last    (last),
    .any_req (any_req),
    .gnt_idx (arb_gnt)
  );

  always_comb begin
    win_awvalid = arb_gnt ? S1_AWVALID : S0_AWVALID;
    sg_awaddr   = gnt ? S1_AWADDR  : S0_AWADDR;
    sg_awvalid  = gnt ? S1_AWVALID : S0_AWVALID;
    sg_wdata    = gnt ? S1_WDATA   : S0_WDATA;
    sg_wstrb    = gnt ? S1_WSTRB   : S0_WSTRB;
    sg_wvalid   = gnt ? S1_WVALID  : S0_WVALID;
    sg_bready   = gnt ? S1_BREADY  : S0_BREADY;
    sg_araddr   = gnt ? S1_ARADDR  : S0_ARADDR;
    sg_arvalid  = gnt ? S1_ARVALID : S0_ARVALID;
    sg_rready   = gnt ? S1_RREADY  : S0_RREADY;
  end

  // Handshakes only count while their channel is still owed.
  assign aw_hs = (state == WR_ADDR) & ~aw_done & sg_awvalid & M_AWREADY;
  assign w_hs  = (state == WR_ADDR) & ~w_done  & sg_wvalid  & M_WREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      last    <= last_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    last_n    = last;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_n   = arb_gnt;
          state_n = win_awvalid ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_n   = WR_RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end else begin
          aw_done_n = aw_done | aw_hs;
          w_done_n  = w_done | w_hs;
        end
      end
      WR_RESP: begin
        if (M_BVALID & sg_bready) begin
          state_n = IDLE;
          last_n  = gnt;
        end
      end
      RD_ADDR: begin
        if (sg_arvalid & M_ARREADY) state_n = RD_DATA;
      end
      RD_DATA: begin
        if (M_RVALID & sg_rready) begin
          state_n = IDLE;
          last_n  = gnt;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    M_AWADDR   = '0;
    M_AWVALID  = 1'b0;
    M_WDATA    = '0;
    M_WSTRB    = '0;
    M_WVALID   = 1'b0;
    M_BREADY   = 1'b0;
    M_ARADDR   = '0;
    M_ARVALID  = 1'b0;
    M_RREADY   = 1'b0;
    up_awready = 1'b0;
    up_wready  = 1'b0;
    up_arready = 1'b0;
    up_bvalid  = 1'b0;
    up_bresp   = RESP_OKAY;
    up_rvalid  = 1'b0;
    up_rresp   = RESP_OKAY;
    up_rdata   = '0;
    case (state)
      WR_ADDR: begin
        if (!aw_done) begin
          M_AWADDR   = sg_awaddr;
          M_AWVALID  = sg_awvalid;
          up_awready = M_AWREADY;
        end
        if (!w_done) begin
          M_WDATA   = sg_wdata;
          M_WSTRB   = sg_wstrb;
          M_WVALID  = sg_wvalid;
          up_wready = M_WREADY;
        end
      end
      WR_RESP: begin
        up_bvalid = M_BVALID;
        up_bresp  = M_BRESP;
        M_BREADY  = sg_bready;
      end
      RD_ADDR: begin
        M_ARADDR   = sg_araddr;
        M_ARVALID  = sg_arvalid;
        up_arready = M_ARREADY;
      end
      RD_DATA: begin
        up_rvalid = M_RVALID;
        up_rdata  = M_RDATA;
        up_rresp  = M_RRESP;
        M_RREADY  = sg_rready;
      end
      default: ;
    endcase
  end

  // Upstream returns go only to the granted master; the other sees zeros.
  always_comb begin
    S0_AWREADY = ~gnt & up_awready;
    S0_WREADY  = ~gnt & up_wready;
    S0_ARREADY = ~gnt & up_arready;
    S0_BVALID  = ~gnt & up_bvalid;
    S0_BRESP   = gnt ? RESP_OKAY : up_bresp;
    S0_RVALID  = ~gnt & up_rvalid;
    S0_RRESP   = gnt ? RESP_OKAY : up_rresp;
    S0_RDATA   = gnt ? '0 : up_rdata;
    S1_AWREADY = gnt & up_awready;
    S1_WREADY  = gnt & up_wready;
    S1_ARREADY = gnt & up_arready;
    S1_BVALID  = gnt & up_bvalid;
    S1_BRESP   = gnt ? up_bresp : RESP_OKAY;
    S1_RVALID  = gnt & up_rvalid;
    S1_RRESP   = gnt ? up_rresp : RESP_OKAY;
    S1_RDATA   = gnt ? up_rdata : '0;
    GNT        = gnt;
    BUSY       = (state != IDLE);
  end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench: two master drivers, a 32-word register-file slave model, and a scoreboard monitor.
module tb_axi4_lite_arbiter_2to1;
  import axi4_lite_pkg::*;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESET;

  logic [31:0] awaddr[2], araddr[2], wdata[2], rdata[2];
  logic [3:0]  wstrb[2];
  logic        awvalid[2], wvalid[2], arvalid[2], bready[2], rready[2];
  logic        awready[2], wready[2], arready[2], bvalid[2], rvalid[2];
  logic [1:0]  bresp[2], rresp[2];

  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [1:0]  M_BRESP, M_RRESP;
  logic        GNT, BUSY;

  axi4_lite_arbiter_2to1 #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S0_AWADDR(awaddr[0]), .S0_AWVALID(awvalid[0]), .S0_AWREADY(awready[0]),
    .S0_WDATA(wdata[0]), .S0_WSTRB(wstrb[0]), .S0_WVALID(wvalid[0]), .S0_WREADY(wready[0]),
    .S0_BRESP(bresp[0]), .S0_BVALID(bvalid[0]), .S0_BREADY(bready[0]),
    .S0_ARADDR(araddr[0]), .S0_ARVALID(arvalid[0]), .S0_ARREADY(arready[0]),
    .S0_RDATA(rdata[0]), .S0_RRESP(rresp[0]), .S0_RVALID(rvalid[0]), .S0_RREADY(rready[0]),
    .S1_AWADDR(awaddr[1]), .S1_AWVALID(awvalid[1]), .S1_AWREADY(awready[1]),
    .S1_WDATA(wdata[1]), .S1_WSTRB(wstrb[1]), .S1_WVALID(wvalid[1]), .S1_WREADY(wready[1]),
    .S1_BRESP(bresp[1]), .S1_BVALID(bvalid[1]), .S1_BREADY(bready[1]),
    .S1_ARADDR(araddr[1]), .S1_ARVALID(arvalid[1]), .S1_ARREADY(arready[1]),
    .S1_RDATA(rdata[1]), .S1_RRESP(rresp[1]), .S1_RVALID(rvalid[1]), .S1_RREADY(rready[1]),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .GNT(GNT), .BUSY(BUSY)
  );

  // Slave model: register file, AW/W accepted independently (W held off until AW in split mode).
  logic [31:0] mem[32];
  logic        slv_aw_got, slv_w_got, slv_bvalid, slv_rvalid, split_mode, init_mem;
  logic [31:0] slv_awaddr, slv_wdata, slv_rdata;
  logic [3:0]  slv_wstrb;
  logic [1:0]  slv_bresp, slv_rresp;
  int          m_aw_cnt = 0;

  assign M_AWREADY = ~slv_aw_got;
  assign M_WREADY  = ~slv_w_got & (~split_mode | slv_aw_got);
  assign M_ARREADY = ~slv_rvalid;
  assign M_BVALID  = slv_bvalid;
  assign M_BRESP   = slv_bresp;
  assign M_RVALID  = slv_rvalid;
  assign M_RDATA   = slv_rdata;
  assign M_RRESP   = slv_rresp;

  always @(posedge ACLK) begin
    if (init_mem)
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
    if (ARESET) begin
      slv_aw_got <= 1'b0;
      slv_w_got  <= 1'b0;
      slv_bvalid <= 1'b0;
      slv_rvalid <= 1'b0;
      slv_bresp  <= RESP_OKAY;
      slv_rresp  <= RESP_OKAY;
      slv_rdata  <= '0;
    end else begin
      if (M_AWVALID && M_AWREADY) begin
        slv_aw_got <= 1'b1;
        slv_awaddr <= M_AWADDR;
        m_aw_cnt   <= m_aw_cnt + 1;
      end
      if (M_WVALID && M_WREADY) begin
        slv_w_got <= 1'b1;
        slv_wdata <= M_WDATA;
        slv_wstrb <= M_WSTRB;
      end
      if (slv_aw_got && slv_w_got && !slv_bvalid) begin
        if (slv_awaddr < 32) begin
          for (int b = 0; b < 4; b++)
            if (slv_wstrb[b]) mem[slv_awaddr[4:0]][b*8 +: 8] <= slv_wdata[b*8 +: 8];
          slv_bresp <= RESP_OKAY;
        end else slv_bresp <= RESP_SLVERR;
        slv_bvalid <= 1'b1;
      end
      if (slv_bvalid && M_BREADY) begin
        slv_bvalid <= 1'b0;
        slv_aw_got <= 1'b0;
        slv_w_got  <= 1'b0;
      end
      if (M_ARVALID && M_ARREADY) begin
        slv_rvalid <= 1'b1;
        if (M_ARADDR < 32) begin
          slv_rdata <= mem[M_ARADDR[4:0]];
          slv_rresp <= RESP_OKAY;
        end else begin
          slv_rdata <= '0;
          slv_rresp <= RESP_SLVERR;
        end
      end
      if (slv_rvalid && M_RREADY) slv_rvalid <= 1'b0;
    end
  end

  int vectors = 0, miscompares = 0, exp_aw_cnt = 0;
  logic [1:0]  exp_b0[$], exp_b1[$];
  logic [33:0] exp_r0[$], exp_r1[$];
  logic        exp_gnt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] er);
    bit aw_ok = 0, w_ok = 0, aw_hs, w_hs;
    int c = 0;
    if (m == 0) exp_b0.push_back(er); else exp_b1.push_back(er);
    exp_aw_cnt++;
    @(posedge ACLK); #1;
    awaddr[m] = a; wdata[m] = d; wstrb[m] = s;
    awvalid[m] = 1'b1; wvalid[m] = 1'b1;
    while (!(aw_ok && w_ok) && c < 100) begin
      @(negedge ACLK);
      aw_hs = awvalid[m] & awready[m];
      w_hs  = wvalid[m] & wready[m];
      @(posedge ACLK); #1;
      if (aw_hs) begin awvalid[m] = 1'b0; aw_ok = 1; end
      if (w_hs)  begin wvalid[m] = 1'b0;  w_ok = 1;  end
      c++;
    end
    if (!(aw_ok && w_ok)) begin
      vectors++; miscompares++;
      $display("FAIL wr_timeout m%0d: got aw=%0d w=%0d expected both accepted", m, aw_ok, w_ok);
      awvalid[m] = 1'b0; wvalid[m] = 1'b0;
    end
  endtask

  task automatic mread(input int m, input logic [31:0] a, input logic [31:0] ed,
                       input logic [1:0] er, input bit push);
    bit ok = 0, hs;
    int c = 0;
    if (push) begin
      if (m == 0) exp_r0.push_back({er, ed}); else exp_r1.push_back({er, ed});
    end
    @(posedge ACLK); #1;
    araddr[m] = a; arvalid[m] = 1'b1;
    while (!ok && c < 100) begin
      @(negedge ACLK);
      hs = arvalid[m] & arready[m];
      @(posedge ACLK); #1;
      if (hs) begin arvalid[m] = 1'b0; ok = 1; end
      c++;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL rd_timeout m%0d: got no AR accept expected accept", m);
      arvalid[m] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_b0.size() + exp_b1.size() + exp_r0.size() + exp_r1.size()
            + exp_gnt.size() != 0 || BUSY) && c < 300) begin
      @(negedge ACLK); c++;
    end
    chk("drain", 64'(exp_b0.size() + exp_b1.size() + exp_r0.size() + exp_r1.size() + exp_gnt.size()), 0);
    repeat (2) @(negedge ACLK);
  endtask

  task automatic reset_pulse();
    @(negedge ACLK); ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  // Scoreboard monitor.
  initial begin
    logic busy_q = 1'b0, cur_gnt = 1'b0, any_out;
    int ng;
    forever begin
      @(negedge ACLK);
      if (BUSY && !busy_q) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          cur_gnt = exp_gnt.pop_front();
          chk("gnt", 64'(GNT), 64'(cur_gnt));
        end
      end
      busy_q = BUSY;
      for (int m = 0; m < 2; m++) begin
        if (bvalid[m] && bready[m]) begin
          if ((m == 0 ? exp_b0.size() : exp_b1.size()) == 0) chk($sformatf("b%0d_unexpected", m), 1, 0);
          else chk($sformatf("bresp%0d", m), 64'(bresp[m]), 64'(m == 0 ? exp_b0.pop_front() : exp_b1.pop_front()));
        end
        if (rvalid[m] && rready[m]) begin
          if ((m == 0 ? exp_r0.size() : exp_r1.size()) == 0) chk($sformatf("r%0d_unexpected", m), 1, 0);
          else chk($sformatf("rresp_rdata%0d", m), 64'({rresp[m], rdata[m]}),
                   64'(m == 0 ? exp_r0.pop_front() : exp_r1.pop_front()));
        end
      end
      if (!BUSY) begin
        any_out = M_AWVALID | M_WVALID | M_ARVALID | M_BREADY | M_RREADY
                | (|M_AWADDR) | (|M_WDATA) | (|M_WSTRB) | (|M_ARADDR);
        for (int m = 0; m < 2; m++)
          any_out |= awready[m] | wready[m] | arready[m] | bvalid[m] | rvalid[m]
                   | (|bresp[m]) | (|rresp[m]) | (|rdata[m]);
        chk("idle_zero", 64'(any_out), 0);
      end else begin
        ng = cur_gnt ? 0 : 1;
        chk("nongnt_zero", 64'({awready[ng], wready[ng], arready[ng], bvalid[ng], rvalid[ng]}), 0);
      end
      if (slv_aw_got) chk("dup_aw", 64'(M_AWVALID), 0);
      if (M_BREADY) chk("bready_after_w", 64'(slv_w_got), 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    ARESET = 1'b1; init_mem = 1'b1; split_mode = 1'b0;
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = '0; araddr[m] = '0; wdata[m] = '0; wstrb[m] = '0;
      awvalid[m] = 0; wvalid[m] = 0; arvalid[m] = 0; bready[m] = 1; rready[m] = 1;
    end
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0; init_mem = 1'b0;
    @(negedge ACLK);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_gnt", 64'(GNT), 0);

    // T1: lone S0 write, forwarded one cycle after the request
    exp_gnt.push_back(0);
    fork
      mwrite(0, 32'd5, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
      begin
        @(posedge ACLK); @(posedge ACLK); @(negedge ACLK);
        chk("t1_awaddr", 64'(M_AWADDR), 5);
        chk("t1_wdata", 64'(M_WDATA), 64'h0000_0000_DEAD_BEEF);
        chk("t1_valids", 64'({M_AWVALID, M_WVALID, M_WSTRB}), 64'h3F);
      end
    join
    wait_idle();

    // T2: simultaneous reads after reset, S0 first
    reset_pulse();
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      mread(0, 32'd3, 32'hA000_0003, RESP_OKAY, 1);
      mread(1, 32'd7, 32'hA000_0007, RESP_OKAY, 1);
    join
    wait_idle();

    // T3: continuous writes from both, grants alternate
    for (int i = 0; i < 6; i++) exp_gnt.push_back(i[0]);
    fork
      for (int i = 0; i < 3; i++) mwrite(0, 32'd8 + 2*i, 32'h1000_0008 + 2*i, 4'hF, RESP_OKAY);
      for (int j = 0; j < 3; j++) mwrite(1, 32'd9 + 2*j, 32'h1000_0009 + 2*j, 4'hF, RESP_OKAY);
    join
    wait_idle();

    // T4: S1 AW and AR together, write first then read back
    exp_gnt.push_back(1); exp_gnt.push_back(1);
    fork
      mwrite(1, 32'd20, 32'h1234_5678, 4'hF, RESP_OKAY);
      mread(1, 32'd20, 32'h1234_5678, RESP_OKAY, 1);
    join
    wait_idle();

    // T5: split AW/W acceptance, partial strobe, SLVERR pass-through, readbacks
    split_mode = 1'b1;
    exp_gnt.push_back(0);
    mwrite(0, 32'd6, 32'hA5A5_0F0F, 4'b0011, RESP_OKAY);
    wait_idle();
    split_mode = 1'b0;
    exp_gnt.push_back(1); exp_gnt.push_back(1); exp_gnt.push_back(0);
    mwrite(1, 32'd40, 32'hCAFE_F00D, 4'hF, RESP_SLVERR);
    mread(1, 32'd40, 32'h0, RESP_SLVERR, 1);
    mread(0, 32'd6, 32'hA000_0F0F, RESP_OKAY, 1);
    wait_idle();
    exp_gnt.push_back(1);
    mread(1, 32'd9, 32'h1000_0009, RESP_OKAY, 1);
    wait_idle();

    // T6: S0 served last, then reset during RD_DATA; next grant must be S0 again
    exp_gnt.push_back(0);
    mread(0, 32'd5, 32'hDEAD_BEEF, RESP_OKAY, 1);
    wait_idle();
    rready[0] = 1'b0;
    exp_gnt.push_back(0);
    mread(0, 32'd3, 32'h0, RESP_OKAY, 0);
    c = 0;
    while (!rvalid[0] && c < 20) begin @(negedge ACLK); c++; end
    chk("t6_rvalid_held", 64'({rvalid[0], M_RVALID, BUSY}), 64'h7);
    @(negedge ACLK); ARESET = 1'b1;
    @(posedge ACLK); #1 ARESET = 1'b0; rready[0] = 1'b1;
    @(negedge ACLK);
    chk("t6_busy", 64'(BUSY), 0);
    chk("t6_valids", 64'({rvalid[0], rvalid[1], M_RREADY, M_ARVALID, M_AWVALID, M_WVALID}), 0);
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      mread(0, 32'd3, 32'hA000_0003, RESP_OKAY, 1);
      mread(1, 32'd7, 32'hA000_0007, RESP_OKAY, 1);
    join
    wait_idle();

    chk("aw_count", 64'(m_aw_cnt), 64'(exp_aw_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
